kgp_instr_sequencer: RTL

//  Multi-cycle control FSM for the KGP-RISC core. Fetches each 32-bit word from instruction memory

---
 rtl/kgp_pkg.sv | 27 ++
 rtl/kgp_bus_timer.sv | 32 +++
 rtl/kgp_instr_sequencer.sv | 139 +++++++++++++
 3 files changed

// File: rtl/kgp_pkg.sv
// Shared definitions for the KGP-RISC instruction sequencer: word size,
// opcode map, FSM state encoding and bus-timer width.
package kgp_pkg;

  localparam int WORD  = 32;
  localparam int TMR_W = 8;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h01;
  localparam logic [5:0] OP_LW    = 6'h02;
  localparam logic [5:0] OP_SW    = 6'h03;
  localparam logic [5:0] OP_BR    = 6'h04;
  localparam logic [5:0] OP_J     = 6'h05;
  localparam logic [5:0] OP_HALT  = 6'h3F;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT,
    S_ERROR
  } state_e;

endpackage

// File: rtl/kgp_bus_timer.sv
// Bus-wait timeout counter. Cleared on every state change of the sequencer,
// counts cycles spent waiting for an ack, flags when the limit is reached.
module kgp_bus_timer
  import kgp_pkg::*;
#(
  parameter int unsigned LIMIT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic tick,
  output logic expired
);

  logic [TMR_W-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == TMR_W'(LIMIT));

  // clear wins over tick; hold at the limit so the counter never wraps
  always_comb begin
    cnt_d = cnt_q;
    if (clr)                  cnt_d = '0;
    else if (tick && !expired) cnt_d = cnt_q + 1'b1;
  end

  // counter register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/kgp_instr_sequencer.sv
// Multi-cycle control FSM for the KGP-RISC core: fetches into the
// instruction register, walks DECODE/EXEC/MEM/WB, owns PC and instret.
module kgp_instr_sequencer
  import kgp_pkg::*;
#(
  parameter logic [WORD-1:0] RESET_PC    = 32'h0000_0000,
  parameter int unsigned     ACK_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            run,
  output logic            imem_req,
  output logic [WORD-1:0] imem_addr,
  input  logic            imem_ack,
  input  logic [WORD-1:0] imem_rdata,
  output logic [WORD-1:0] instr,
  input  logic [5:0]      opcode,
  input  logic [WORD-1:0] imm,
  input  logic [WORD-1:0] imm2,
  input  logic            branch_taken,
  output logic            dmem_req,
  output logic            dmem_we,
  input  logic            dmem_ack,
  output logic            rf_we,
  output logic [WORD-1:0] pc,
  output logic            halted,
  output logic            error,
  output logic [WORD-1:0] instret
);

  state_e          state_q, state_d;
  logic [WORD-1:0] pc_q, pc_d;
  logic [WORD-1:0] instr_q, instr_d;
  logic [WORD-1:0] instret_q, instret_d;
  logic            tmr_clr, tmr_tick, tmr_expired;

  // Strobes decode straight from the state register so an async reset
  // drops them immediately.
  assign imem_req  = (state_q == S_FETCH);
  assign imem_addr = imem_req ? pc_q : '0;
  assign dmem_req  = (state_q == S_MEM);
  assign dmem_we   = dmem_req && (opcode == OP_SW);
  assign rf_we     = (state_q == S_WB);
  assign halted    = (state_q == S_HALT);
  assign error     = (state_q == S_ERROR);
  assign instr     = instr_q;
  assign pc        = pc_q;
  assign instret   = instret_q;

  // Any state change restarts the wait count, so FETCH and MEM always
  // begin from zero; only an un-acked request cycle advances it.
  assign tmr_clr  = (state_d != state_q);
  assign tmr_tick = ((state_q == S_FETCH) && !imem_ack) ||
                    ((state_q == S_MEM)   && !dmem_ack);

  kgp_bus_timer #(.LIMIT(ACK_TIMEOUT)) u_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (tmr_clr),
    .tick    (tmr_tick),
    .expired (tmr_expired)
  );

  // Next-state, PC, instruction register and retire counter
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    instret_d = instret_q;
    unique case (state_q)
      S_IDLE: if (run) state_d = S_FETCH;
      S_FETCH: begin
        // an ack on the expiry cycle still completes the fetch
        if (imem_ack) begin
          instr_d = imem_rdata;
          state_d = S_DECODE;
        end else if (tmr_expired) begin
          state_d = S_ERROR;
        end
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        unique case (opcode)
          OP_RTYPE, OP_ADDI: state_d = S_WB;
          OP_LW, OP_SW:      state_d = S_MEM;
          OP_BR: begin
            pc_d      = branch_taken ? pc_q + 32'd4 + imm : pc_q + 32'd4;
            instret_d = instret_q + 32'd1;
            state_d   = S_FETCH;
          end
          OP_J: begin
            pc_d      = pc_q + 32'd4 + imm2;
            instret_d = instret_q + 32'd1;
            state_d   = S_FETCH;
          end
          OP_HALT: state_d = S_HALT;
          default: state_d = S_ERROR;
        endcase
      end
      S_MEM: begin
        if (dmem_ack) begin
          if (opcode == OP_SW) begin
            pc_d      = pc_q + 32'd4;
            instret_d = instret_q + 32'd1;
            state_d   = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (tmr_expired) begin
          state_d = S_ERROR;
        end
      end
      S_WB: begin
        pc_d      = pc_q + 32'd4;
        instret_d = instret_q + 32'd1;
        state_d   = S_FETCH;
      end
      S_HALT:  state_d = S_HALT;
      S_ERROR: state_d = S_ERROR;
      default: state_d = S_ERROR;
    endcase
  end

  // Architectural state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= RESET_PC;
      instr_q   <= '0;
      instret_q <= '0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      instret_q <= instret_d;
    end
  end

endmodule
